// File: rtl/cmp8_search.sv
// Successive-approximation search engine that drives comparator operand `a` and binary-searches the unknown `b`.
// Optional build macro CMP8_SEARCH_ONEHOT_CHECK_EN traps non-one-hot comparator flags into ERR.
module cmp8_search #(
  parameter int W       = 8,
  parameter int CMP_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [W-1:0] guess,
  input  logic         cmp_eq,
  input  logic         cmp_gt,
  input  logic         cmp_lt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] found,
  output logic [3:0]   steps,
  output logic         error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  localparam logic [W-1:0] MAX_VAL   = '1;
  localparam logic [3:0]   WAIT_INIT = 4'(CMP_LAT - 1);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] guess_q, guess_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] hi_q, hi_d;
  logic [3:0]   wait_q, wait_d;
  logic [3:0]   steps_q, steps_d;
  logic [W-1:0] found_q, found_d;

  logic [W-1:0] lo_n, hi_n;
  logic [W:0]   mid_sum;
  logic         reload;
  logic         flags_ok;

  // Exactly one bit set: odd parity rules out 000 and 011-style pairs, the AND rules out 111.
  assign flags_ok = (cmp_eq ^ cmp_gt ^ cmp_lt) & ~(cmp_eq & cmp_gt & cmp_lt);

  always_comb begin
    state_d = state_q;
    guess_d = guess_q;
    wait_d  = wait_q;
    steps_d = steps_q;
    found_d = found_q;
    lo_n    = lo_q;
    hi_n    = hi_q;
    reload  = 1'b0;

    case (state_q)
      S_SEARCH: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          steps_d = steps_q + 4'd1;
`ifdef CMP8_SEARCH_ONEHOT_CHECK_EN
          if (!flags_ok) begin
            state_d = S_ERR;
          end else
`endif
          if (cmp_eq) begin
            state_d = S_DONE;
            found_d = guess_q;
          end else if (cmp_gt) begin
            if (guess_q == lo_q) begin
              state_d = S_ERR;
            end else begin
              hi_n   = guess_q - W'(1);
              reload = 1'b1;
            end
          end else begin
            // Without the one-hot check, 000 falls through here and is treated as lt.
            if (guess_q == hi_q) begin
              state_d = S_ERR;
            end else begin
              lo_n   = guess_q + W'(1);
              reload = 1'b1;
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_SEARCH;
          lo_n    = '0;
          hi_n    = MAX_VAL;
          steps_d = 4'd0;
          reload  = 1'b1;
        end
      end
    endcase

    mid_sum = {1'b0, lo_n} + {1'b0, hi_n};
    if (reload) begin
      guess_d = mid_sum[W:1];
      wait_d  = WAIT_INIT;
    end
    lo_d = lo_n;
    hi_d = hi_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      guess_q <= '0;
      lo_q    <= '0;
      hi_q    <= MAX_VAL;
      wait_q  <= 4'd0;
      steps_q <= 4'd0;
      found_q <= '0;
    end else begin
      state_q <= state_d;
      guess_q <= guess_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      wait_q  <= wait_d;
      steps_q <= steps_d;
      found_q <= found_d;
    end
  end

  assign guess = guess_q;
  assign found = found_q;
  assign steps = steps_q;
  assign busy  = (state_q == S_SEARCH);
  assign done  = (state_q == S_DONE);
  assign error = (state_q == S_ERR);

endmodule
